// File: rtl/core_pkg.sv
// Shared definitions for the 5-stage core pipeline control logic.
package core_pkg;

    localparam int REG_ADDR_W = 5;

    // addi x0, x0, 0: the instruction the flush muxes load into IF/ID and ID/EX
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MDU_BUSY = 2'd1,
        MDU_HOLD = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_bubble;
        logic mdu_start;
    } hz_ctrl_t;

    // Normal EX advance; the caller guarantees the memory stage is not waiting.
    // A taken branch wins over load-use because the ID instruction is wrong-path.
    function automatic hz_ctrl_t advance_ctrl(input logic branchTaken, input logic loadUse);
        hz_ctrl_t c;
        c = '0;
        c.pc_en     = 1'b1;
        c.if_id_en  = 1'b1;
        c.id_ex_en  = 1'b1;
        c.ex_mem_en = 1'b1;
        c.mem_wb_en = 1'b1;
        if (branchTaken) begin
            c.if_id_flush = 1'b1;
            c.id_ex_flush = 1'b1;
        end else if (loadUse) begin
            c.pc_en       = 1'b0;
            c.if_id_en    = 1'b0;
            c.id_ex_flush = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch flushes, MDU
// multi-cycle holds and data-memory wait states, plus a stall-cycle counter.
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [REG_ADDR_W-1:0] rs1_label_if_id_i,
    input  logic [REG_ADDR_W-1:0] rs2_label_if_id_i,
    input  logic                  rs1_used_id_i,
    input  logic                  rs2_used_id_i,
    input  logic [REG_ADDR_W-1:0] rd_label_id_ex_i,
    input  logic                  reg_wb_en_id_ex_i,
    input  logic                  is_load_id_ex_i,
    input  logic                  branch_taken_ex_i,
    input  logic                  is_mdu_id_ex_i,
    input  logic                  mdu_done_i,
    output logic                  mdu_start_o,
    input  logic                  dmem_req_mem_i,
    input  logic                  dmem_ready_i,
    output logic                  pc_en_o,
    output logic                  if_id_en_o,
    output logic                  id_ex_en_o,
    output logic                  ex_mem_en_o,
    output logic                  mem_wb_en_o,
    output logic                  if_id_flush_o,
    output logic                  id_ex_flush_o,
    output logic                  ex_mem_bubble_o,
    output logic [CNT_W-1:0]      stall_cycles_o
);

    hz_state_t        state_q, state_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    hz_ctrl_t         ctrl;
    logic             memStall;
    logic             loadUse;
    logic             rs1Hit;
    logic             rs2Hit;

    assign memStall = dmem_req_mem_i & ~dmem_ready_i;
    assign rs1Hit   = rs1_used_id_i & (rs1_label_if_id_i == rd_label_id_ex_i);
    assign rs2Hit   = rs2_used_id_i & (rs2_label_if_id_i == rd_label_id_ex_i);
    assign loadUse  = is_load_id_ex_i & reg_wb_en_id_ex_i &
                      (rd_label_id_ex_i != '0) & (rs1Hit | rs2Hit);

    // Control vector defaults to a full freeze; only the cases that move the
    // pipe override it, so flushes can never appear while EX is held.
    always_comb begin
        ctrl    = '0;
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (is_mdu_id_ex_i && !memStall) begin
                    ctrl.mem_wb_en     = 1'b1;
                    ctrl.ex_mem_bubble = 1'b1;
                    ctrl.mdu_start     = 1'b1;
                    state_d            = MDU_BUSY;
                end else if (!memStall) begin
                    ctrl = advance_ctrl(branch_taken_ex_i, loadUse);
                end
            end
            MDU_BUSY: begin
                if (!memStall) begin
                    if (mdu_done_i) begin
                        ctrl    = advance_ctrl(branch_taken_ex_i, loadUse);
                        state_d = RUN;
                    end else begin
                        ctrl.mem_wb_en     = 1'b1;
                        ctrl.ex_mem_bubble = 1'b1;
                    end
                end else if (mdu_done_i) begin
                    state_d = MDU_HOLD;
                end
            end
            MDU_HOLD: begin
                if (!memStall) begin
                    ctrl    = advance_ctrl(branch_taken_ex_i, loadUse);
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        if (!rst_ni) begin
            ctrl             = '0;
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (!ctrl.pc_en && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
        end
    end

    assign pc_en_o         = ctrl.pc_en;
    assign if_id_en_o      = ctrl.if_id_en;
    assign id_ex_en_o      = ctrl.id_ex_en;
    assign ex_mem_en_o     = ctrl.ex_mem_en;
    assign mem_wb_en_o     = ctrl.mem_wb_en;
    assign if_id_flush_o   = ctrl.if_id_flush;
    assign id_ex_flush_o   = ctrl.id_ex_flush;
    assign ex_mem_bubble_o = ctrl.ex_mem_bubble;
    assign mdu_start_o     = ctrl.mdu_start;
    assign stall_cycles_o  = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl; a second instance with a 3-bit
// counter exercises saturation on the same stimulus.
module tb_hazard_ctrl;

    // Control vector order: pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush, bubble, start
    localparam logic [8:0] C_RUN    = 9'b11111_000_0;
    localparam logic [8:0] C_LDUSE  = 9'b00111_010_0;
    localparam logic [8:0] C_BRANCH = 9'b11111_110_0;
    localparam logic [8:0] C_START  = 9'b00001_001_1;
    localparam logic [8:0] C_BUSY   = 9'b00001_001_0;
    localparam logic [8:0] C_FREEZE = 9'b00000_000_0;
    localparam logic [8:0] C_RESET  = 9'b00000_110_0;

    logic        clk;
    logic        rstN;
    logic [4:0]  rs1, rs2, rd;
    logic        rs1Used, rs2Used, wbEn, isLoad, brTaken, isMdu, mduDone, dmemReq, dmemReady;

    logic        pcEn, ifIdEn, idExEn, exMemEn, memWbEn, ifIdFlush, idExFlush, bubble, mduStart;
    logic [31:0] stallCycles;
    logic        pcEn2, ifIdEn2, idExEn2, exMemEn2, memWbEn2, ifIdFlush2, idExFlush2, bubble2, mduStart2;
    logic [2:0]  stallCycles2;
    logic [8:0]  ctrlObs, ctrlObs2;

    int          checkCount = 0;
    int          errorCount = 0;
    int          expStall   = 0;

    assign ctrlObs  = {pcEn, ifIdEn, idExEn, exMemEn, memWbEn, ifIdFlush, idExFlush, bubble, mduStart};
    assign ctrlObs2 = {pcEn2, ifIdEn2, idExEn2, exMemEn2, memWbEn2, ifIdFlush2, idExFlush2, bubble2, mduStart2};

    hazard_ctrl #(.CNT_W(32)) dut (
        .clk_i(clk), .rst_ni(rstN),
        .rs1_label_if_id_i(rs1), .rs2_label_if_id_i(rs2),
        .rs1_used_id_i(rs1Used), .rs2_used_id_i(rs2Used),
        .rd_label_id_ex_i(rd), .reg_wb_en_id_ex_i(wbEn), .is_load_id_ex_i(isLoad),
        .branch_taken_ex_i(brTaken), .is_mdu_id_ex_i(isMdu), .mdu_done_i(mduDone),
        .mdu_start_o(mduStart), .dmem_req_mem_i(dmemReq), .dmem_ready_i(dmemReady),
        .pc_en_o(pcEn), .if_id_en_o(ifIdEn), .id_ex_en_o(idExEn), .ex_mem_en_o(exMemEn),
        .mem_wb_en_o(memWbEn), .if_id_flush_o(ifIdFlush), .id_ex_flush_o(idExFlush),
        .ex_mem_bubble_o(bubble), .stall_cycles_o(stallCycles)
    );

    hazard_ctrl #(.CNT_W(3)) dutSat (
        .clk_i(clk), .rst_ni(rstN),
        .rs1_label_if_id_i(rs1), .rs2_label_if_id_i(rs2),
        .rs1_used_id_i(rs1Used), .rs2_used_id_i(rs2Used),
        .rd_label_id_ex_i(rd), .reg_wb_en_id_ex_i(wbEn), .is_load_id_ex_i(isLoad),
        .branch_taken_ex_i(brTaken), .is_mdu_id_ex_i(isMdu), .mdu_done_i(mduDone),
        .mdu_start_o(mduStart2), .dmem_req_mem_i(dmemReq), .dmem_ready_i(dmemReady),
        .pc_en_o(pcEn2), .if_id_en_o(ifIdEn2), .id_ex_en_o(idExEn2), .ex_mem_en_o(exMemEn2),
        .mem_wb_en_o(memWbEn2), .if_id_flush_o(ifIdFlush2), .id_ex_flush_o(idExFlush2),
        .ex_mem_bubble_o(bubble2), .stall_cycles_o(stallCycles2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                                 input logic [4:0] d, input logic wb, input logic ld, input logic br,
                                 input logic mdu, input logic done, input logic req, input logic rdy);
        rs1 = r1;  rs1Used = u1;  rs2 = r2;  rs2Used = u2;
        rd = d;    wbEn = wb;     isLoad = ld;
        brTaken = br;  isMdu = mdu;  mduDone = done;
        dmemReq = req; dmemReady = rdy;
    endtask

    // Checks the combinational control for the current cycle, clocks once,
    // then checks both counters against the bench's running stall count.
    task automatic runVec(input string tag, input logic [8:0] expCtrl, input logic countStall);
        #1;
        checkOutput({tag, "_ctrl"}, 32'(ctrlObs), 32'(expCtrl));
        checkOutput({tag, "_ctrlSat"}, 32'(ctrlObs2), 32'(expCtrl));
        if (countStall) expStall++;
        @(posedge clk);
        #1;
        checkOutput({tag, "_stall"}, stallCycles, 32'(expStall));
        checkOutput({tag, "_stallSat"}, 32'(stallCycles2), (expStall > 7) ? 32'd7 : 32'(expStall));
    endtask

    initial begin
        rstN = 1'b0;
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("reset_ctrl", 32'(ctrlObs), 32'(C_RESET));
        checkOutput("reset_stall", stallCycles, 32'd0);
        @(posedge clk);
        #1;
        rstN = 1'b1;

        //            rs1   u1    rs2   u2    rd    wb    ld    br    mdu   done  req   rdy
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        runVec("idle", C_RUN, 1'b0);
        applyStimulus(5'd5, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        runVec("ldUseRs1", C_LDUSE, 1'b1);
        applyStimulus(5'd5, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        runVec("afterLdUse", C_RUN, 1'b0);
        applyStimulus(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        runVec("loadX0", C_RUN, 1'b0);
        applyStimulus(5'd5, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        runVec("ldUseRs2", C_LDUSE, 1'b1);
        applyStimulus(5'd5, 1'b0, 5'd2, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        runVec("rs1Unused", C_RUN, 1'b0);
        applyStimulus(5'd5, 1'b1, 5'd2, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        runVec("loadNoWb", C_RUN, 1'b0);
        applyStimulus(5'd5, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        runVec("branchLdUse", C_BRANCH, 1'b0);
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        runVec("memStallRun", C_FREEZE, 1'b1);
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        runVec("memReady", C_RUN, 1'b0);

        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        runVec("mduStart", C_START, 1'b1);
        runVec("mduBusy1", C_BUSY, 1'b1);
        runVec("mduBusy2", C_BUSY, 1'b1);
        runVec("mduBusy3", C_BUSY, 1'b1);
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        runVec("mduDone", C_RUN, 1'b0);
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        runVec("mduBackRun", C_RUN, 1'b0);

        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        runVec("mdu2Start", C_START, 1'b1);
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        runVec("busyMemStall", C_FREEZE, 1'b1);
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        runVec("doneMemStall", C_FREEZE, 1'b1);
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        runVec("hold1", C_FREEZE, 1'b1);
        runVec("hold2", C_FREEZE, 1'b1);
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        runVec("holdRelease", C_BRANCH, 1'b0);
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        runVec("holdBackRun", C_RUN, 1'b0);

        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        runVec("mdu3Start", C_START, 1'b1);
        runVec("mdu3Busy", C_BUSY, 1'b1);

        // Asynchronous reset in the middle of an MDU_BUSY cycle
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("asyncRst_ctrl", 32'(ctrlObs), 32'(C_RESET));
        checkOutput("asyncRst_stall", stallCycles, 32'd0);
        checkOutput("asyncRst_stallSat", 32'(stallCycles2), 32'd0);
        #2;
        rstN = 1'b1;
        expStall = 0;
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        runVec("postRst", C_RUN, 1'b0);
        applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        runVec("postRstMdu", C_START, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
